program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter WORDS, default 64, meaning instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning byte-address width of the instruction-memory write port.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a program load.
REQ-006 SHALL have port in_valid  input  1  source presents a byte on in_data.
REQ-007 SHALL have port in_data  input  8  stream byte.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port mem_addr  output  ADDR_W  word-aligned byte address of the write.
REQ-011 SHALL have port mem_wdata  output  32  instruction word to write.
REQ-012 SHALL have port cpu_hold  output  1  high holds the datapath in reset.
REQ-013 SHALL have port done  output  1  load completed with a good checksum.
REQ-014 SHALL have port error  output  1  load aborted (bad length or checksum).

Function
REQ-015 SHALL transfer a byte only on a rising edge where in_valid and in_ready are both high; the source holds the byte otherwise.
REQ-016 SHALL implement states IDLE, LEN, DATA, WRITE, CHECK, DONE, ERR.
REQ-017 SHALL, in IDLE, DONE or ERR, on start=1 enter LEN next cycle, clear done, error, word index and checksum, and drive cpu_hold=1.
REQ-018 SHALL ignore start in LEN, DATA, WRITE and CHECK.
REQ-019 SHALL drive in_ready=1 only in LEN, DATA and CHECK.
REQ-020 SHALL, in LEN, take the accepted byte as word count N, with N=0 meaning WORDS.
REQ-021 SHALL, on N>WORDS, enter ERR the next cycle with no memory write.
REQ-022 SHALL, on a valid N, enter DATA the next cycle.
REQ-023 SHALL assemble 4 accepted bytes per word, MSB first (first byte to bits 31:24).
REQ-024 SHALL enter WRITE after the 4th byte; WRITE lasts exactly one cycle with mem_we=1, mem_addr=4*word_index, mem_wdata=assembled word.
REQ-025 SHALL keep mem_we=0 in every other state, mem_addr and mem_wdata holding the last value.
REQ-026 SHALL increment word_index after WRITE, then enter CHECK if word_index equals N, else DATA.
REQ-027 SHALL maintain checksum as XOR of the length byte and all data bytes.
REQ-028 SHALL, in CHECK, enter DONE if the accepted byte equals checksum, else ERR.
REQ-029 SHALL drive done=1, cpu_hold=0 in DONE; error=1, cpu_hold=1 in ERR; both flags 0 elsewhere.
REQ-030 SHALL never write mem_addr above 4*(WORDS-1); no wrap-around.

Reset
REQ-031 SHALL, on reset=0 at a rising edge, enter IDLE with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, counters and checksum zero.
REQ-032 SHALL, on reset mid-load, discard any partial word; words already written remain in memory; no further writes until a new start.

Verification
REQ-033 SHALL verify: reset=0 two cycles -> cpu_hold=1, done=0, error=0, mem_we=0, in_ready=0.
REQ-034 SHALL verify: start, bytes 02 20 01 00 05 8C 01 00 00 AB -> writes (0x00, 0x20010005) then (0x04, 0x8C010000), each mem_we one cycle; then done=1, cpu_hold=0.
REQ-035 SHALL verify: same stream with checksum 00 -> both writes occur, then error=1, done=0, cpu_hold=1.
REQ-036 SHALL verify: start, length 0x41 -> error=1 next cycle, mem_we never asserted.
REQ-037 SHALL verify: length 00 plus 256 data bytes with random in_valid gaps -> exactly 64 writes, last at mem_addr 0xFC, in_ready=0 on every WRITE cycle, no byte lost or duplicated.
REQ-038 SHALL verify: reset=0 after length 02 and 6 data bytes -> exactly one write (addr 0x00), IDLE, cpu_hold=1, no later writes until start.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed, XOR-checksummed byte stream,
// packs it MSB-first into 32-bit instruction words, writes them to
// instruction memory and holds the CPU in reset until a good load completes.
module program_loader #(
   parameter int WORDS  = 64,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   // Counters must hold values 0..WORDS inclusive (index reaches N == WORDS).
   localparam int CNT_W = $clog2(WORDS + 1);

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      WRITE,
      CHECK,
      DONE,
      ERR
   } state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    len_reg, len_next;
   logic [CNT_W-1:0]    index_reg, index_next;
   logic [1:0]          byte_cnt_reg, byte_cnt_next;
   logic [23:0]         word_reg, word_next;      // first three bytes of the word in flight
   logic [7:0]          sum_reg, sum_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [31:0]         wdata_reg, wdata_next;

   // Length byte widened so an out-of-range count can be detected before truncation.
   logic [31:0]         len_value;
   assign len_value = (in_data == 8'd0) ? 32'(WORDS) : {24'd0, in_data};

   // State and datapath registers; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= IDLE;
         len_reg      <= '0;
         index_reg    <= '0;
         byte_cnt_reg <= '0;
         word_reg     <= '0;
         sum_reg      <= '0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         len_reg      <= len_next;
         index_reg    <= index_next;
         byte_cnt_reg <= byte_cnt_next;
         word_reg     <= word_next;
         sum_reg      <= sum_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
      end
   end

   // Next-state, datapath updates and state-decoded handshake/strobe outputs.
   always_comb begin
      state_next    = state_reg;
      len_next      = len_reg;
      index_next    = index_reg;
      byte_cnt_next = byte_cnt_reg;
      word_next     = word_reg;
      sum_next      = sum_reg;
      addr_next     = addr_reg;
      wdata_next    = wdata_reg;
      in_ready      = 1'b0;
      mem_we        = 1'b0;

      case (state_reg)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_next    = LEN;
               index_next    = '0;
               byte_cnt_next = '0;
               sum_next      = '0;
            end
         end
         LEN: begin
            in_ready = 1'b1;
            if (in_valid) begin
               sum_next = sum_reg ^ in_data;
               if (len_value > 32'(WORDS)) begin
                  state_next = ERR;
               end else begin
                  len_next   = CNT_W'(len_value);
                  state_next = DATA;
               end
            end
         end
         DATA: begin
            in_ready = 1'b1;
            if (in_valid) begin
               sum_next      = sum_reg ^ in_data;
               word_next     = {word_reg[15:0], in_data};
               byte_cnt_next = byte_cnt_reg + 2'd1;
               if (byte_cnt_reg == 2'd3) begin
                  // Latch the complete word and its address; they stay put after WRITE.
                  wdata_next = {word_reg, in_data};
                  addr_next  = ADDR_W'({index_reg, 2'b00});
                  state_next = WRITE;
               end
            end
         end
         WRITE: begin
            mem_we     = 1'b1;
            index_next = index_reg + CNT_W'(1);
            if (index_reg + CNT_W'(1) == len_reg) begin
               state_next = CHECK;
            end else begin
               state_next = DATA;
            end
         end
         CHECK: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = (in_data == sum_reg) ? DONE : ERR;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign cpu_hold  = (state_reg != DONE);
   assign done      = (state_reg == DONE);
   assign error     = (state_reg == ERR);

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized and directed loads; a reference model derives
// expected memory writes into a queue that a write monitor consumes.
module tb_program_loader;

   localparam int WORDS  = 64;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'd0;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;

   program_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   int          vectors = 0;
   int          miscompares = 0;
   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [7:0]  stim_q[$];
   bit          exp_done;
   bit          exp_err;
   int          exp_n;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic finish_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   endtask

   // Write monitor: every mem_we cycle must match the oldest expected write.
   always @(negedge clk) begin
      if (mem_we) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     mem_addr, mem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("write_addr", 32'(mem_addr), 32'(mon_e.addr));
            check("write_data", mem_wdata, mon_e.data);
            check("ready_low_in_write", 32'(in_ready), 32'd0);
         end
      end
   end

   // Reference model: interpret stim_q as length, 4*N data bytes, checksum.
   task automatic model_load();
      logic [7:0] sum;
      wr_t        w;
      exp_n = (stim_q[0] == 8'd0) ? WORDS : int'(stim_q[0]);
      if (exp_n > WORDS) begin
         exp_done = 1'b0;
         exp_err  = 1'b1;
         return;
      end
      sum = stim_q[0];
      for (int i = 0; i < exp_n; i++) begin
         w.addr = ADDR_W'(4 * i);
         w.data = {stim_q[1 + 4*i], stim_q[2 + 4*i], stim_q[3 + 4*i], stim_q[4 + 4*i]};
         for (int k = 1; k <= 4; k++) sum = sum ^ stim_q[k + 4*i];
         exp_q.push_back(w);
      end
      exp_done = (stim_q[1 + 4*exp_n] == sum);
      exp_err  = !exp_done;
   endtask

   // Random stream with a correct or deliberately wrong checksum.
   task automatic build_stream(input logic [7:0] len_byte, input bit good);
      int         n;
      logic [7:0] sum;
      logic [7:0] b;
      stim_q.delete();
      stim_q.push_back(len_byte);
      n = (len_byte == 8'd0) ? WORDS : int'(len_byte);
      if (n > WORDS) return;
      sum = len_byte;
      for (int i = 0; i < 4*n; i++) begin
         b = 8'($urandom);
         sum = sum ^ b;
         stim_q.push_back(b);
      end
      if (!good) sum = sum ^ 8'($urandom_range(255, 1));
      stim_q.push_back(sum);
   endtask

   // Present one byte after a random idle gap and hold it until accepted.
   task automatic send_byte(input logic [7:0] b, input int gap_max, input bit noise);
      int g;
      g = $urandom_range(gap_max, 0);
      repeat (g) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      start    = noise ? 1'($urandom) : 1'b0;
      for (int w = 0; ; w++) begin
         @(negedge clk);
         if (in_ready) break;
         if (w > 50) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, expected 1", w);
            finish_run();
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      start    = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("len_ready", 32'(in_ready), 32'd1);
      check("len_hold", 32'(cpu_hold), 32'd1);
      check("len_flags", 32'({done, error}), 32'd0);
   endtask

   // Full load of stim_q: model, stream, then outcome and held write port.
   task automatic run_load(input int gap_max, input bit noise);
      wr_t last;
      pulse_start();
      model_load();
      if (exp_q.size() > 0) last = exp_q[exp_q.size() - 1];
      if (exp_n > WORDS) begin
         send_byte(stim_q[0], gap_max, noise);
      end else begin
         foreach (stim_q[i]) send_byte(stim_q[i], gap_max, noise);
      end
      check("end_done", 32'(done), 32'(exp_done));
      check("end_error", 32'(error), 32'(exp_err));
      check("end_hold", 32'(cpu_hold), 32'(!exp_done));
      check("writes_pending", 32'(exp_q.size()), 32'd0);
      if (exp_n <= WORDS) begin
         check("addr_held", 32'(mem_addr), 32'(last.addr));
         check("wdata_held", mem_wdata, last.data);
      end
   endtask

   initial begin
      // Reset held two cycles.
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold", 32'(cpu_hold), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Two-word program with good checksum.
      stim_q = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h01, 8'h00, 8'h00, 8'hAB};
      run_load(0, 1'b0);

      // Same program, bad checksum.
      stim_q = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h01, 8'h00, 8'h00, 8'h00};
      run_load(1, 1'b0);

      // Oversized length: error right after the length byte, no writes.
      stim_q = '{8'h41};
      run_load(0, 1'b0);

      // Length 0 means a full 64-word memory, with random source gaps.
      build_stream(8'h00, 1'b1);
      run_load(3, 1'b1);
      check("full_last_addr", 32'(mem_addr), 32'hFC);

      // Reset in the middle of the second word.
      build_stream(8'h02, 1'b1);
      pulse_start();
      model_load();
      void'(exp_q.pop_back());
      for (int i = 0; i < 7; i++) send_byte(stim_q[i], 1, 1'b0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      check("midrst_hold", 32'(cpu_hold), 32'd1);
      check("midrst_ready", 32'(in_ready), 32'd0);
      check("midrst_flags", 32'({done, error}), 32'd0);
      check("midrst_writes_pending", 32'(exp_q.size()), 32'd0);
      in_valid = 1'b1;
      repeat (20) begin
         in_data = 8'($urandom);
         @(posedge clk);
         #1;
      end
      check("midrst_still_idle_ready", 32'(in_ready), 32'd0);
      check("midrst_still_hold", 32'(cpu_hold), 32'd1);
      in_valid = 1'b0;

      // Randomized loads, including out-of-range lengths and bad checksums.
      for (int t = 0; t < 8; t++) begin
         logic [7:0] lb;
         case ($urandom_range(5, 0))
            0:       lb = 8'($urandom_range(255, 65));
            1:       lb = 8'h00;
            default: lb = 8'($urandom_range(12, 1));
         endcase
         build_stream(lb, ($urandom_range(3, 0) != 0));
         run_load(2, 1'b1);
      end

      finish_run();
   end

endmodule
